// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one i2c_simple_master between NUM_REQ clients.
// It loads the winner's bytes, strobes the master, waits for completion, retries
// NACKed transfers up to MAX_RETRY times and reports one status pulse per request.
module i2c_txn_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned BUSY_TIMEOUT = 1024,
  parameter int unsigned DONE_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [3*NUM_REQ-1:0]  req_len,
  input  logic [64*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_id,
  output logic [1:0]            rsp_status,
  output logic                  arb_busy,
  output logic                  m_start,
  output logic [7:0]            m_data [0:7],
  output logic [2:0]            m_num_bytes,
  input  logic                  m_busy,
  input  logic                  m_done,
  input  logic                  m_ack_error
);

  localparam int unsigned MaxTimeout = (BUSY_TIMEOUT > DONE_TIMEOUT) ? BUSY_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned TimerW     = $clog2(MaxTimeout + 1);
  localparam int unsigned RetryW     = $clog2(MAX_RETRY + 2);
  localparam int unsigned IdW        = $clog2(NUM_REQ);

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusNack    = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;
  localparam logic [1:0] StatusBadLen  = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StLoad, StStrobe, StWaitBusy, StWaitDone, StWaitIdle, StResp
  } state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [1:0]          status_q, status_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                ack_err_q, ack_err_d;
  logic [TimerW-1:0]   timer_q;
  logic [IdW-1:0]      rr_q;
  logic [NUM_REQ-1:0]  mask_q;
  logic [7:0]          data_q [0:7];
  logic [2:0]          nbytes_q;

  logic [2:0]          len_arr  [NUM_REQ];
  logic [63:0]         data_arr [NUM_REQ];
  logic                grant_valid;
  logic [IdW-1:0]      grant_id;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign len_arr[r]  = req_len[3*r +: 3];
    assign data_arr[r] = req_data[64*r +: 64];
  end

  // Round-robin search: first unmasked request strictly after the last winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [IdW-1:0] idx;
      idx = IdW'((32'(rr_q) + k) % NUM_REQ);
      if (!grant_valid && req[idx] && !mask_q[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // State and transaction context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      id_q      <= '0;
      status_q  <= StatusOk;
      retry_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      status_q  <= status_d;
      retry_q   <= retry_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Timer, rr pointer, post-ack mask and the byte/count latch feeding the master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      rr_q     <= IdW'(NUM_REQ - 1);
      mask_q   <= '0;
      nbytes_q <= '0;
      for (int b = 0; b < 8; b++) data_q[b] <= '0;
    end else begin
      if (state_d != state_q) timer_q <= '0;
      else if (timer_q != '1) timer_q <= timer_q + 1'b1;
      if (state_q == StIdle && grant_valid) rr_q <= grant_id;
      // Keep the just-acked requester out of the very next arbitration.
      mask_q <= (state_q == StResp) ? (NUM_REQ'(1) << id_q) : '0;
      if (state_q == StLoad) begin
        nbytes_q <= len_arr[id_q];
        for (int b = 0; b < 8; b++) data_q[b] <= data_arr[id_q][8*b +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    status_d  = status_q;
    retry_d   = retry_q;
    ack_err_d = ack_err_q;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          id_d      = grant_id;
          retry_d   = '0;
          ack_err_d = 1'b0;
          if (len_arr[grant_id] == 3'd0) begin
            status_d = StatusBadLen;
            state_d  = StResp;
          end else begin
            status_d = StatusOk;
            state_d  = StLoad;
          end
        end
      end
      StLoad:   state_d = StStrobe;
      StStrobe: begin
        ack_err_d = 1'b0;
        state_d   = StWaitBusy;
      end
      StWaitBusy: begin
        if (m_busy) begin
          state_d = StWaitDone;
        end else if (timer_q == TimerW'(BUSY_TIMEOUT)) begin
          status_d = StatusTimeout;
          state_d  = StResp;
        end
      end
      StWaitDone: begin
        if (m_done) begin
          ack_err_d = m_ack_error;
          state_d   = StWaitIdle;
        end else if (timer_q == TimerW'(DONE_TIMEOUT)) begin
          status_d = StatusTimeout;
          state_d  = StWaitIdle;
        end
      end
      StWaitIdle: begin
        // The master cannot be aborted, so its busy must clear before anything else.
        if (!m_busy) begin
          if (ack_err_q && retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StStrobe;
          end else begin
            if (ack_err_q) status_d = StatusNack;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        retry_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ack    = '0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_status = '0;
    m_start    = 1'b0;
    arb_busy   = (state_q != StIdle);
    if (state_q == StResp) begin
      req_ack    = NUM_REQ'(1) << id_q;
      rsp_valid  = 1'b1;
      rsp_id     = 3'(id_q);
      rsp_status = status_q;
    end
    if (state_q == StStrobe) m_start = 1'b1;
  end

  assign m_data      = data_q;
  assign m_num_bytes = nbytes_q;

endmodule
